// File: rtl/ss_key_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ss_key_detect_pkg
// Purpose  : Shared types and constants for the save-state key detector.
// Revision : 1.0 - initial release
// ============================================================================
package ss_key_detect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } SsState;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SAVE = 2'd1,
        LOAD = 2'd2,
        MENU = 2'd3
    } SsReq;

    // Pad bit positions, sample order {S,A,C,B,R,L,D,U}
    localparam int c_pad_u = 0;
    localparam int c_pad_d = 1;
    localparam int c_pad_l = 2;
    localparam int c_pad_r = 3;
    localparam int c_pad_b = 4;
    localparam int c_pad_c = 5;
    localparam int c_pad_a = 6;
    localparam int c_pad_s = 7;

    // A zero key register disables its combo
    function automatic logic combo_hit(input logic [7:0] key, input logic [7:0] smp);
        return (key != 8'd0) && (smp == key);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_debounce.sv
`default_nettype none
// ============================================================================
// Module   : ss_debounce
// Purpose  : 2-flop synchroniser, stability counter and rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ss_debounce #(
    parameter logic [15:0] DEB_CYC = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_stable;
    logic        r_rise;
    logic [15:0] r_cnt;
    logic [16:0] w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= 16'd0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            // Any return to the stable level restarts the stability window
            if (r_sync2 == r_stable) begin
                r_cnt <= 16'd0;
            end else if (w_cnt_inc >= {1'b0, DEB_CYC}) begin
                r_stable <= r_sync2;
                r_rise   <= r_sync2;
                r_cnt    <= 16'd0;
            end else begin
                r_cnt <= w_cnt_inc[15:0];
            end
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/ss_key_detect.sv
`default_nettype none
// ============================================================================
// Module   : ss_key_detect
// Purpose  : Detects held pad combos (or an external button when built with
//            SS_EXT_BTN_EN) and raises save/load/menu requests until ack.
// Revision : 1.0 - initial release
// ============================================================================
module ss_key_detect
    import ss_key_detect_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 3,
    parameter logic [15:0] DEB_CYC     = 16'd50000
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       ss_on,
    input  logic       ss_btn,
    input  logic [7:0] key_save,
    input  logic [7:0] key_load,
    input  logic [7:0] key_menu,
    input  logic [7:0] pad,
    input  logic       pad_vld,
    input  logic       vsync,
    input  logic       ext_btn,
    input  logic       ack,
    output logic       req_save,
    output logic       req_load,
    output logic       req_menu,
    output logic       busy
);

    localparam logic [3:0] c_hold_tgt = 4'(HOLD_FRAMES);

    SsState     r_state;
    SsReq       r_cand;
    SsReq       w_new_req;
    logic [3:0] r_hold_cnt;
    logic [7:0] r_pad;
    logic [7:0] w_pad_nxt;
    logic [7:0] w_cand_key;
    logic       r_req_save;
    logic       r_req_load;
    logic       r_req_menu;
    logic       w_btn_rise;
    logic       w_btn_mode;

`ifdef SS_EXT_BTN_EN
    ss_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk    (clk),
        .rst    (map_rst),
        .i_btn  (ext_btn),
        .o_rise (w_btn_rise)
    );
    assign w_btn_mode = ss_btn;
`else
    logic w_unused_ext;
    assign w_unused_ext = &{1'b0, ext_btn, ss_btn, DEB_CYC};
    assign w_btn_rise   = 1'b0;
    assign w_btn_mode   = 1'b0;
`endif

    // Comparisons look at the value pad_r is about to take
    assign w_pad_nxt = pad_vld ? pad : r_pad;

    always_comb begin
        w_new_req = NONE;
        if (combo_hit(key_menu, w_pad_nxt))      w_new_req = MENU;
        else if (combo_hit(key_save, w_pad_nxt)) w_new_req = SAVE;
        else if (combo_hit(key_load, w_pad_nxt)) w_new_req = LOAD;
    end

    // Live key register value so a cfg change mid-hold is re-checked
    always_comb begin
        w_cand_key = 8'd0;
        case (r_cand)
            SAVE:    w_cand_key = key_save;
            LOAD:    w_cand_key = key_load;
            MENU:    w_cand_key = key_menu;
            default: w_cand_key = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_state    <= IDLE;
            r_cand     <= NONE;
            r_hold_cnt <= 4'd0;
            r_pad      <= 8'd0;
            r_req_save <= 1'b0;
            r_req_load <= 1'b0;
            r_req_menu <= 1'b0;
        end else begin
            r_pad <= w_pad_nxt;
            if (!ss_on) begin
                r_state    <= IDLE;
                r_hold_cnt <= 4'd0;
                r_req_save <= 1'b0;
                r_req_load <= 1'b0;
                r_req_menu <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_btn_mode) begin
                            if (w_btn_rise) begin
                                r_state    <= REQ;
                                r_cand     <= MENU;
                                r_req_menu <= 1'b1;
                            end
                        end else if (pad_vld && (w_new_req != NONE)) begin
                            r_state    <= HOLD;
                            r_cand     <= w_new_req;
                            r_hold_cnt <= 4'd0;
                        end
                    end
                    HOLD: begin
                        // A mismatching sample wins over a coincident vsync
                        if (pad_vld && !combo_hit(w_cand_key, w_pad_nxt)) begin
                            r_state <= IDLE;
                        end else if (r_hold_cnt >= c_hold_tgt) begin
                            r_state    <= REQ;
                            r_req_save <= (r_cand == SAVE);
                            r_req_load <= (r_cand == LOAD);
                            r_req_menu <= (r_cand == MENU);
                        end else if (vsync && (r_hold_cnt != 4'hF)) begin
                            r_hold_cnt <= r_hold_cnt + 4'd1;
                        end
                    end
                    REQ: begin
                        if (ack) begin
                            r_state    <= RELEASE;
                            r_req_save <= 1'b0;
                            r_req_load <= 1'b0;
                            r_req_menu <= 1'b0;
                        end
                    end
                    RELEASE: begin
                        if (pad_vld && (pad == 8'd0)) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign req_save = r_req_save;
    assign req_load = r_req_load;
    assign req_menu = r_req_menu;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire
